// File: rtl/spike_pkg.sv
// Shared definitions for the spike readout path.
// Holds the record layout, the saturation limit, the default sizes and small helpers.
package spike_pkg;

    localparam int REC_W    = 16;
    localparam int FIELD_W  = 8;
    localparam int ISI_LSB  = 8;
    localparam int PEAK_LSB = 0;

    localparam logic [7:0] ISI_MAX = 8'd255;

    localparam int DEF_FIFO_DEPTH  = 4;
    localparam int DEF_WINDOW_LOG2 = 8;

    // The ISI field sits in the upper byte, so a packed
    // struct matches the offsets above.
    typedef struct packed {
        logic [7:0] isi;
        logic [7:0] peak;
    } evt_rec_t;

    function automatic logic [7:0] sat_inc(logic [7:0] v);
        return (v == ISI_MAX) ? v : v + 8'd1;
    endfunction

    function automatic logic [7:0] max8(logic [7:0] a, logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spike_monitor_if.sv
// Event record handshake between the spike monitor and its consumer.
// master: evt_valid/evt_isi/evt_peak out, evt_ready in; slave: the reverse.
interface spike_monitor_if;

    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_isi;
    logic [7:0] evt_peak;

    modport master (
        output evt_valid,
        output evt_isi,
        output evt_peak,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_isi,
        input  evt_peak,
        output evt_ready
    );

endinterface

// File: rtl/event_fifo.sv
// First-word fall-through FIFO for event records, async active-high reset.
// Ports: clk, rst, push/wdata, pop/rdata, full, empty.
module event_fifo
    import spike_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int W     = REC_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         do_pop;
    logic         do_push;

    // Extra pointer bit tells full from empty when the indices match.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);

    assign do_pop  = pop & ~empty;
    // A pop frees the slot in the same cycle, so full+pop still accepts.
    assign do_push = push & (~full | do_pop);

    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr[AW-1:0]] <= wdata;
                wptr <= wptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/spike_monitor.sv
// Spike readout: onset detect, ISI/peak capture into an event FIFO, windowed rate.
// Ports: clk, rst, en, state, spike, evt (master), rate, rate_valid, overflow, clr_ovf.
module spike_monitor
    import spike_pkg::*;
#(
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int WINDOW_LOG2 = DEF_WINDOW_LOG2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [7:0]             state,
    input  logic [7:0]             spike,
    spike_monitor_if.master        evt,
    output logic [7:0]             rate,
    output logic                   rate_valid,
    output logic                   overflow,
    input  logic                   clr_ovf
);

    logic                   s_d;
    logic [7:0]             isi_cnt;
    logic [7:0]             peak_reg;
    logic [7:0]             spk_cnt;
    logic [WINDOW_LOG2-1:0] win_cnt;

    logic     onset;
    logic     pop;
    logic     full;
    logic     empty;
    logic     drop;
    evt_rec_t rec;
    evt_rec_t head;
    logic     spike_hi_unused;

    assign spike_hi_unused = |spike[7:1];

    assign onset = spike[0] & ~s_d & en;

    assign rec.isi  = isi_cnt;
    assign rec.peak = max8(peak_reg, state);

    assign pop  = ~empty & evt.evt_ready;
    assign drop = onset & full & ~pop;

    event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (onset),
        .wdata (rec),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign evt.evt_valid = ~empty;
    assign evt.evt_isi   = head.isi;
    assign evt.evt_peak  = head.peak;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_d        <= 1'b0;
            isi_cnt    <= '0;
            peak_reg   <= '0;
            spk_cnt    <= '0;
            win_cnt    <= '0;
            rate       <= '0;
            rate_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            s_d        <= spike[0];
            rate_valid <= 1'b0;

            // isi_cnt is zero only until the first onset, so it
            // doubles as the "first onset seen" flag.
            if (onset) begin
                isi_cnt  <= 8'd1;
                peak_reg <= '0;
            end else if (en) begin
                if (isi_cnt != '0) begin
                    isi_cnt <= sat_inc(isi_cnt);
                end
                peak_reg <= max8(peak_reg, state);
            end

            if (en) begin
                win_cnt <= win_cnt + WINDOW_LOG2'(1);
                if (&win_cnt) begin
                    rate       <= onset ? sat_inc(spk_cnt) : spk_cnt;
                    spk_cnt    <= '0;
                    rate_valid <= 1'b1;
                end else if (onset) begin
                    spk_cnt <= sat_inc(spk_cnt);
                end
            end

            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
